// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing and ALU_Op generation.
// Optional macro MC_JUMP_EN builds the JUMP state; otherwise OP_J decodes as illegal.
module mips_mc_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       Mem_Ready,
  output logic       PC_En,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] ALU_Op,
  output logic       Illegal_Op,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10
`ifdef MC_JUMP_EN
    , S_JUMP    = 4'd11
`endif
  } state_t;

  state_t     state_r;
  state_t     next_s;
  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       mem_to_reg_s;
  logic       reg_dst_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] pc_src_s;
  logic [1:0] alu_op_s;
  logic       illegal_s;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and per-state datapath control decode
  always_comb begin
    next_s          = state_r;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    iord_s          = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    pc_src_s        = 2'b00;
    alu_op_s        = 2'b00;
    illegal_s       = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        if (Mem_Ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          next_s     = S_DECODE;
        end else begin
          next_s     = S_FETCH;
        end
      end
      S_DECODE: begin
        // PC + (imm << 2) is precomputed here so BRANCH can use ALUOut
        alu_src_b_s = 2'b11;
        if ((Op == OP_LW) || (Op == OP_SW)) begin
          next_s = S_MEM_ADDR;
        end else if (Op == OP_RTYPE) begin
          next_s = S_EXECUTE;
        end else if (Op == OP_BEQ) begin
          next_s = S_BRANCH;
        end else if (Op == OP_ADDI) begin
          next_s = S_ADDI_EXEC;
        end else if (Op == OP_J) begin
`ifdef MC_JUMP_EN
          next_s    = S_JUMP;
`else
          next_s    = S_FETCH;
          illegal_s = 1'b1;
`endif
        end else begin
          next_s    = S_FETCH;
          illegal_s = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (Op == OP_LW) begin
          next_s = S_MEM_READ;
        end else begin
          next_s = S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
        if (Mem_Ready) begin
          next_s = S_MEM_WB;
        end else begin
          next_s = S_MEM_READ;
        end
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        next_s       = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
        if (Mem_Ready) begin
          next_s = S_FETCH;
        end else begin
          next_s = S_MEM_WRITE;
        end
      end
      S_EXECUTE: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
        next_s      = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
        next_s      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_src_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        next_s          = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        alu_op_s    = 2'b11;
        next_s      = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_s = 1'b1;
        next_s      = S_FETCH;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pc_src_s   = 2'b10;
        pc_write_s = 1'b1;
        next_s     = S_FETCH;
      end
`endif
      default: begin
        next_s = S_FETCH;
      end
    endcase
  end

  // Output stage: reset forces every output low so an aborted write never reaches the datapath
  always_comb begin
    if (rst) begin
      PC_En      = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      MemtoReg   = 1'b0;
      RegDst     = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
      ALU_Op     = 2'b00;
      Illegal_Op = 1'b0;
      State      = 4'd0;
    end else begin
      PC_En      = pc_write_s | (pc_write_cond_s & Zero);
      IorD       = iord_s;
      MemRead    = mem_read_s;
      MemWrite   = mem_write_s;
      IRWrite    = ir_write_s;
      MemtoReg   = mem_to_reg_s;
      RegDst     = reg_dst_s;
      RegWrite   = reg_write_s;
      ALUSrcA    = alu_src_a_s;
      ALUSrcB    = alu_src_b_s;
      PCSrc      = pc_src_s;
      ALU_Op     = alu_op_s;
      Illegal_Op = illegal_s;
      State      = state_r;
    end
  end

  mips_mc_control_chk u_chk (
    .clk        (clk),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .PC_En      (PC_En),
    .PCSrc      (PCSrc),
    .Illegal_Op (Illegal_Op),
    .State      (State)
  );

endmodule

// Protocol invariants on the control outputs.
module mips_mc_control_chk (
  input logic       clk,
  input logic       MemRead,
  input logic       MemWrite,
  input logic       RegWrite,
  input logic       PC_En,
  input logic [1:0] PCSrc,
  input logic       Illegal_Op,
  input logic [3:0] State
);

  a_mem_excl:  assert property (@(posedge clk) !(MemRead && MemWrite));
  a_wr_excl:   assert property (@(posedge clk) !(RegWrite && PC_En));
  a_ill_dec:   assert property (@(posedge clk) Illegal_Op |-> (State == 4'd1));
`ifndef MC_JUMP_EN
  a_no_jump:   assert property (@(posedge clk) PCSrc != 2'b10);
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: directed test-plan steps followed by randomized instruction streams
// checked against a phase-list model of each instruction.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic       Zero;
  logic       Mem_Ready;
  logic       PC_En, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc, ALU_Op;
  logic       Illegal_Op;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

`ifdef MC_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEM_ADDR = 2, P_MEM_READ = 3, P_MEM_WB = 4,
                 P_MEM_WRITE = 5, P_EXECUTE = 6, P_ALU_WB = 7, P_BRANCH = 8,
                 P_ADDI_EXEC = 9, P_ADDI_WB = 10, P_JUMP = 11;

  mips_mc_control dut (
    .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .PC_En(PC_En), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALU_Op(ALU_Op), .Illegal_Op(Illegal_Op), .State(State)
  );

  always #5 clk = ~clk;

  wire [15:0] obs = {PC_En, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                     ALUSrcA, ALUSrcB, PCSrc, ALU_Op, Illegal_Op};

  function automatic logic [15:0] pack(input logic pc_en, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
                                       input logic [1:0] srcb, pcsrc, aluop, input logic ill);
    return {pc_en, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcsrc, aluop, ill};
  endfunction

  // Expected control word for one phase of an instruction
  function automatic logic [15:0] exp_out(input int ph, input logic z, input logic rdy, input logic ill);
    case (ph)
      P_FETCH:     return pack(rdy, 1'b0, 1'b1, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
      P_DECODE:    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, ill);
      P_MEM_ADDR:  return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
      P_MEM_READ:  return pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
      P_MEM_WB:    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
      P_MEM_WRITE: return pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
      P_EXECUTE:   return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0);
      P_ALU_WB:    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
      P_BRANCH:    return pack(z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0);
      P_ADDI_EXEC: return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b11, 1'b0);
      P_ADDI_WB:   return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
      P_JUMP:      return pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0);
      default:     return 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [19:0] observed, input logic [19:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Hold reset for n cycles; every output, State included, must read zero
  task automatic do_reset(input int n, input logic rdy, input logic [5:0] op, input string tag);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      Mem_Ready = rdy;
      Op        = op;
      Zero      = 1'($urandom);
      #4;
      check($sformatf("%s.rst%0d", tag, i), {State, obs}, 20'h00000);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Run one instruction: fw/mw are Mem_Ready-low cycles in fetch/memory phase; abort_at >= 0 resets at that cycle
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                           input int abort_at, input string tag);
    int  q[$];
    int  ph, cyc, fcnt, mcnt, base, exp_cycles;
    bit  ill, has_mem, mem_ph;
    q = {};
    q.push_back(P_FETCH);
    q.push_back(P_DECODE);
    ill = 1'b0;
    has_mem = 1'b0;
    case (op)
      6'b100011: begin q.push_back(P_MEM_ADDR); q.push_back(P_MEM_READ); q.push_back(P_MEM_WB); has_mem = 1'b1; base = 5; end
      6'b101011: begin q.push_back(P_MEM_ADDR); q.push_back(P_MEM_WRITE); has_mem = 1'b1; base = 4; end
      6'b000000: begin q.push_back(P_EXECUTE); q.push_back(P_ALU_WB); base = 4; end
      6'b000100: begin q.push_back(P_BRANCH); base = 3; end
      6'b001000: begin q.push_back(P_ADDI_EXEC); q.push_back(P_ADDI_WB); base = 4; end
      6'b000010: begin
        if (JUMP_EN) begin q.push_back(P_JUMP); base = 3; end
        else begin ill = 1'b1; base = 2; end
      end
      default:   begin ill = 1'b1; base = 2; end
    endcase
    exp_cycles = base + fw + (has_mem ? mw : 0);
    cyc = 0;
    fcnt = 0;
    mcnt = 0;
    while (q.size() != 0 && cyc < 64) begin
      ph = q[0];
      mem_ph = (ph == P_MEM_READ) || (ph == P_MEM_WRITE);
      Op   = ((ph == P_DECODE) || (ph == P_MEM_ADDR)) ? op : 6'($urandom);
      Zero = (ph == P_BRANCH) ? z : 1'($urandom);
      if (ph == P_FETCH) begin
        Mem_Ready = (fcnt >= fw);
        fcnt++;
      end else if (mem_ph) begin
        Mem_Ready = (mcnt >= mw);
        mcnt++;
      end else begin
        Mem_Ready = 1'($urandom);
      end
      if (cyc == abort_at) begin
        do_reset(1, Mem_Ready, Op, $sformatf("%s.abort", tag));
        return;
      end
      #4;
      check($sformatf("%s.c%0d", tag, cyc), {State, obs},
            {4'(ph), exp_out(ph, Zero, Mem_Ready, ill && (ph == P_DECODE))});
      check($sformatf("%s.excl%0d", tag, cyc), 20'({MemRead & MemWrite, RegWrite & PC_En}), 20'h00000);
      @(posedge clk);
      #1;
      cyc++;
      if (!(((ph == P_FETCH) || mem_ph) && !Mem_Ready)) void'(q.pop_front());
    end
    check($sformatf("%s.latency", tag), 20'(cyc), 20'(exp_cycles));
  endtask

  logic [5:0] ops [7];
  logic [5:0] rop;

  initial begin
    rst = 1'b1;
    Op = 6'b000000;
    Zero = 1'b0;
    Mem_Ready = 1'b0;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b111111;
    @(posedge clk);
    #1;
    do_reset(2, 1'b1, 6'b100011, "reset");
    run_instr(6'b100011, 1'b0, 0, 0, -1, "lw");
    run_instr(6'b101011, 1'b0, 0, 3, -1, "sw_wait3");
    run_instr(6'b000100, 1'b1, 0, 0, -1, "beq_taken");
    run_instr(6'b000100, 1'b0, 0, 0, -1, "beq_not");
    run_instr(6'b000000, 1'b0, 0, 0, -1, "rtype");
    run_instr(6'b001000, 1'b0, 0, 0, -1, "addi");
    run_instr(6'b000010, 1'b0, 0, 0, -1, "j");
    run_instr(6'b111111, 1'b0, 0, 0, -1, "illegal");
    run_instr(6'b100011, 1'b0, 2, 2, -1, "lw_waits");
    run_instr(6'b100011, 1'b0, 0, 2, 3, "lw_abort_memread");
    run_instr(6'b101011, 1'b0, 0, 2, 3, "sw_abort_memwrite");
    run_instr(6'b000000, 1'b0, 0, 0, 0, "rt_abort_fetch");
    for (int i = 0; i < 300; i++) begin
      rop = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 5) == 0) rop = 6'($urandom);
      run_instr(rop, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1,
                $sformatf("rnd%0d_op%02h", i, rop));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
